// File: rtl/oled_spi_rx.sv
// ----------------------------------------------------------------------------
// oled_spi_rx
//
// Receives the OLED controller SPI stream from an external host, reassembles
// bytes, and turns data bytes into framebuffer write strobes.
//
// Optional feature macro: OLED_RX_ADDR_TRACK_EN
//   defined   : column/page address parser (0x21/0x22 windows, 0xAE/0xAF
//               display on/off), auto-incrementing write pointers.
//   undefined : no parser; every data byte writes page 0, column 0 and
//               disp_on is held low.
//
// Ports
//   CLK, RST             system clock, synchronous active-high reset
//   CS, SCLK, SDIN, DC   asynchronous SPI lines (CS active-low, DC 1 = data)
//   byte_data/byte_dc    last received byte and its DC bit (held)
//   byte_vld             1-cycle strobe when a new byte is available
//   wr_en/wr_page/wr_col/wr_data  framebuffer write strobe, address, data
//   disp_on              display-on flag
//   frag_err             1-cycle pulse when CS rises on a partial byte
// ----------------------------------------------------------------------------
module oled_spi_rx #(
    parameter int COL_W = 7,
    parameter int PG_W  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CS,
    input  logic             SCLK,
    input  logic             SDIN,
    input  logic             DC,
    output logic [7:0]       byte_data,
    output logic             byte_dc,
    output logic             byte_vld,
    output logic             wr_en,
    output logic [PG_W-1:0]  wr_page,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic             disp_on,
    output logic             frag_err
);

    // ------------------------------------------------------------------
    // Input synchronizers; index [1] is the synchronized value.
    // CS idles high and SCLK idles low so reset never fakes an edge.
    // ------------------------------------------------------------------
    logic [1:0] r_cs_sync;
    logic [1:0] r_sclk_sync;
    logic [1:0] r_sdin_sync;
    logic [1:0] r_dc_sync;
    logic       r_cs_prev;
    logic       r_sclk_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_sdin_sync <= 2'b00;
            r_dc_sync   <= 2'b00;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], CS};
            r_sclk_sync <= {r_sclk_sync[0], SCLK};
            r_sdin_sync <= {r_sdin_sync[0], SDIN};
            r_dc_sync   <= {r_dc_sync[0], DC};
            r_cs_prev   <= r_cs_sync[1];
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    logic       w_cs_rise;
    logic       w_bit_edge;
    logic       w_byte_done;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_cnt_next;
    logic [6:0] r_shift;

    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_prev;
    // An SCLK edge seen in the same cycle CS deasserts still belongs to the
    // frame, so a byte finishing exactly at CS release is completed.
    assign w_bit_edge  = r_sclk_sync[1] & ~r_sclk_prev & (~r_cs_sync[1] | w_cs_rise);
    assign w_byte_done = w_bit_edge & (r_bit_cnt == 3'd7);
    // 3-bit counter wraps to 0 on the 8th bit.
    assign w_cnt_next  = w_bit_edge ? r_bit_cnt + 3'd1 : r_bit_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            byte_data <= 8'd0;
            byte_dc   <= 1'b0;
            byte_vld  <= 1'b0;
            frag_err  <= 1'b0;
        end else begin
            byte_vld  <= w_byte_done;
            frag_err  <= w_cs_rise & (w_cnt_next != 3'd0);
            r_bit_cnt <= w_cs_rise ? 3'd0 : w_cnt_next;
            if (w_bit_edge) begin
                r_shift <= {r_shift[5:0], r_sdin_sync[1]};
            end
            if (w_byte_done) begin
                byte_data <= {r_shift, r_sdin_sync[1]};
                byte_dc   <= r_dc_sync[1];
            end
        end
    end

    assign wr_data = byte_data;
    assign wr_en   = byte_vld & byte_dc;

`ifdef OLED_RX_ADDR_TRACK_EN
    // ------------------------------------------------------------------
    // Command parser: walks through argument bytes of 0x21/0x22. A data
    // byte arriving while an argument is expected aborts the command and
    // is written like any other data byte.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_IDLE,
        P_COL_A,
        P_COL_B,
        P_PG_A,
        P_PG_B
    } p_state_t;

    p_state_t         r_state;
    p_state_t         w_state_next;
    logic [COL_W-1:0] r_col_start;
    logic [COL_W-1:0] r_col_end;
    logic [COL_W-1:0] r_col;
    logic [PG_W-1:0]  r_pg_start;
    logic [PG_W-1:0]  r_pg_end;
    logic [PG_W-1:0]  r_pg;
    logic             r_disp_on;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= P_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (byte_vld) begin
            if (byte_dc) begin
                w_state_next = P_IDLE;
            end else begin
                case (r_state)
                    P_IDLE: begin
                        if (byte_data == 8'h21) begin
                            w_state_next = P_COL_A;
                        end else if (byte_data == 8'h22) begin
                            w_state_next = P_PG_A;
                        end
                    end
                    P_COL_A: w_state_next = P_COL_B;
                    P_PG_A:  w_state_next = P_PG_B;
                    default: w_state_next = P_IDLE;
                endcase
            end
        end
    end

    // Window registers and write pointers. Commands and writes both act
    // only on byte_vld, and bytes are serial, so they never collide.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_col_start <= '0;
            r_col_end   <= '1;
            r_col       <= '0;
            r_pg_start  <= '0;
            r_pg_end    <= '1;
            r_pg        <= '0;
            r_disp_on   <= 1'b0;
        end else if (byte_vld) begin
            if (byte_dc) begin
                if (r_col == r_col_end) begin
                    r_col <= r_col_start;
                    r_pg  <= (r_pg == r_pg_end) ? r_pg_start : r_pg + PG_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else begin
                case (r_state)
                    P_IDLE: begin
                        if (byte_data == 8'hAE) begin
                            r_disp_on <= 1'b0;
                        end else if (byte_data == 8'hAF) begin
                            r_disp_on <= 1'b1;
                        end
                    end
                    P_COL_A: begin
                        r_col_start <= byte_data[COL_W-1:0];
                        r_col       <= byte_data[COL_W-1:0];
                    end
                    P_COL_B: r_col_end <= byte_data[COL_W-1:0];
                    P_PG_A: begin
                        r_pg_start <= byte_data[PG_W-1:0];
                        r_pg       <= byte_data[PG_W-1:0];
                    end
                    P_PG_B:  r_pg_end <= byte_data[PG_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign wr_page = r_pg;
    assign wr_col  = r_col;
    assign disp_on = r_disp_on;
`else
    assign wr_page = '0;
    assign wr_col  = '0;
    assign disp_on = 1'b0;
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// ----------------------------------------------------------------------------
// tb_oled_spi_rx
//
// Self-checking bench for oled_spi_rx. Drives the SPI pins slowly relative to
// CLK, collects every byte_vld cycle into a queue, and compares each one with
// a behavioural model of the receiver/address-tracking rules. Follows the
// OLED_RX_ADDR_TRACK_EN macro the same way the design does.
// ----------------------------------------------------------------------------
module tb_oled_spi_rx;
    localparam int COL_W = 7;
    localparam int PG_W  = 2;

    logic             CLK  = 1'b0;
    logic             RST  = 1'b1;
    logic             CS   = 1'b1;
    logic             SCLK = 1'b0;
    logic             SDIN = 1'b0;
    logic             DC   = 1'b0;
    logic [7:0]       byte_data;
    logic             byte_dc;
    logic             byte_vld;
    logic             wr_en;
    logic [PG_W-1:0]  wr_page;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_data;
    logic             disp_on;
    logic             frag_err;

    oled_spi_rx #(.COL_W(COL_W), .PG_W(PG_W)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .SDIN(SDIN), .DC(DC),
        .byte_data(byte_data), .byte_dc(byte_dc), .byte_vld(byte_vld),
        .wr_en(wr_en), .wr_page(wr_page), .wr_col(wr_col), .wr_data(wr_data),
        .disp_on(disp_on), .frag_err(frag_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]       d;
        logic             dc;
        logic             we;
        logic [PG_W-1:0]  pg;
        logic [COL_W-1:0] col;
        logic [7:0]       wd;
    } obs_t;

    obs_t obs_q[$];
    int   frag_cnt = 0;
    int   vld_long = 0;
    int   frag_long = 0;
    int   wr_bad = 0;
    logic vld_prev = 1'b0;
    logic frag_prev = 1'b0;

    int checks = 0;
    int errors = 0;

    // Monitor: every strobe cycle is recorded, sampled on the falling edge.
    always @(negedge CLK) begin
        obs_t o;
        if (byte_vld) begin
            o = {byte_data, byte_dc, wr_en, wr_page, wr_col, wr_data};
            obs_q.push_back(o);
        end
        if (frag_err) frag_cnt++;
        if (byte_vld && vld_prev) vld_long++;
        if (frag_err && frag_prev) frag_long++;
        if (wr_en && !(byte_vld && byte_dc)) wr_bad++;
        vld_prev  = byte_vld;
        frag_prev = frag_err;
    end

    // ---------------- behavioural model ----------------
    int m_col_lo, m_col_hi, m_pg_lo, m_pg_hi, m_col, m_pg, m_arg;
    logic             m_disp;
    logic             exp_we;
    logic [PG_W-1:0]  exp_pg;
    logic [COL_W-1:0] exp_col;

    task automatic model_reset();
        m_col_lo = 0; m_col_hi = 127; m_pg_lo = 0; m_pg_hi = 3;
        m_col = 0; m_pg = 0; m_arg = 0; m_disp = 1'b0;
    endtask

    // m_arg: 0 none pending, 1/2 first/second column arg, 3/4 page args
    task automatic model_byte(input bit dc, input int b);
        exp_we = 1'b0; exp_pg = '0; exp_col = '0;
`ifdef OLED_RX_ADDR_TRACK_EN
        if (dc) begin
            m_arg   = 0;
            exp_we  = 1'b1;
            exp_pg  = PG_W'(m_pg);
            exp_col = COL_W'(m_col);
            if (m_col == m_col_hi) begin
                m_col = m_col_lo;
                m_pg  = (m_pg == m_pg_hi) ? m_pg_lo : (m_pg + 1) % 4;
            end else begin
                m_col = (m_col + 1) % 128;
            end
        end else begin
            case (m_arg)
                0: begin
                    if (b == 'h21) m_arg = 1;
                    else if (b == 'h22) m_arg = 3;
                    else if (b == 'hAE) m_disp = 1'b0;
                    else if (b == 'hAF) m_disp = 1'b1;
                end
                1: begin m_col_lo = b % 128; m_col = m_col_lo; m_arg = 2; end
                2: begin m_col_hi = b % 128; m_arg = 0; end
                3: begin m_pg_lo = b % 4; m_pg = m_pg_lo; m_arg = 4; end
                default: begin m_pg_hi = b % 4; m_arg = 0; end
            endcase
        end
`else
        exp_we = dc;
`endif
    endtask

    // ---------------- pin drivers ----------------
    task automatic clock_bits(input logic [7:0] b, input bit dc, input int n, input bit end_cs);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge CLK);
            SDIN = b[i];
            DC   = dc;
            repeat (2) @(negedge CLK);
            SCLK = 1'b1;
            if (i == 0 && end_cs) CS = 1'b1;
            repeat (2) @(negedge CLK);
            SCLK = 1'b0;
        end
    endtask

    task automatic run_byte(input logic [7:0] b, input bit dc, input bit end_cs,
                            output obs_t got, output obs_t exp, output bit seen);
        model_byte(dc, int'(b));
        exp = {b, dc, exp_we, exp_pg, exp_col, b};
        clock_bits(b, dc, 8, end_cs);
        seen = 1'b0;
        got  = '0;
        for (int k = 0; k < 20 && obs_q.size() == 0; k++) @(negedge CLK);
        if (obs_q.size() > 0) begin
            got  = obs_q.pop_front();
            seen = 1'b1;
        end
        $display("tx data=%h dc=%0d we=%0d page=%0d col=%0d wdata=%h disp=%0d",
                 got.d, got.dc, got.we, got.pg, got.col, got.wd, disp_on);
    endtask

    task automatic cs_low();
        @(negedge CLK);
        CS = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; CS = 1'b1; SCLK = 1'b0; SDIN = 1'b0; DC = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        obs_q.delete();
        @(negedge CLK);
        checks++;
        if ({byte_data, byte_dc, byte_vld, wr_en, wr_page, wr_col, wr_data, disp_on, frag_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h dc=%0d vld=%0d we=%0d pg=%0d col=%0d wd=%h disp=%0d frag=%0d required all 0",
                     byte_data, byte_dc, byte_vld, wr_en, wr_page, wr_col, wr_data, disp_on, frag_err);
        end
    endtask

    task automatic test_single();
        obs_t got, exp; bit seen;
        cs_low();
        run_byte(8'hA5, 1'b1, 1'b0, got, exp, seen);
        checks++;
        if (!seen || got !== exp) begin
            errors++;
            $display("FAIL single_byte got=%h seen=%0d required=%h", got, seen, exp);
        end
        checks++;
        if (!seen || got.d !== 8'hA5 || got.dc !== 1'b1 || got.we !== 1'b1 || got.pg !== '0 || got.col !== '0) begin
            errors++;
            $display("FAIL single_literal got=%h required data=a5 dc=1 we=1 page=0 col=0", got);
        end
    endtask

    task automatic test_col_window();
        obs_t got, exp; bit seen;
        logic [7:0] cmds [3];
        logic [COL_W-1:0] lit_col [4];
        logic [PG_W-1:0]  lit_pg [4];
        cmds[0] = 8'h21; cmds[1] = 8'h10; cmds[2] = 8'h12;
        lit_col[0] = 7'h10; lit_col[1] = 7'h11; lit_col[2] = 7'h12; lit_col[3] = 7'h10;
        lit_pg[0] = 2'd0; lit_pg[1] = 2'd0; lit_pg[2] = 2'd0; lit_pg[3] = 2'd1;
        test_reset();
        cs_low();
        for (int i = 0; i < 3; i++) begin
            run_byte(cmds[i], 1'b0, 1'b0, got, exp, seen);
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL col_cmd%0d got=%h seen=%0d required=%h", i, got, seen, exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            run_byte(8'($urandom), 1'b1, 1'b0, got, exp, seen);
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL col_data%0d got=%h seen=%0d required=%h", i, got, seen, exp);
            end
`ifdef OLED_RX_ADDR_TRACK_EN
            checks++;
            if (got.col !== lit_col[i] || got.pg !== lit_pg[i]) begin
                errors++;
                $display("FAIL col_addr%0d got page=%0d col=%h required page=%0d col=%h",
                         i, got.pg, got.col, lit_pg[i], lit_col[i]);
            end
`endif
        end
    endtask

    task automatic test_page_wrap();
        obs_t got, exp; bit seen;
        logic [7:0] cmds [3];
        cmds[0] = 8'h22; cmds[1] = 8'h03; cmds[2] = 8'h03;
        test_reset();
        cs_low();
        for (int i = 0; i < 3; i++) begin
            run_byte(cmds[i], 1'b0, 1'b0, got, exp, seen);
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL pg_cmd%0d got=%h seen=%0d required=%h", i, got, seen, exp);
            end
        end
        for (int i = 0; i < 130; i++) begin
            run_byte(8'($urandom), 1'b1, 1'b0, got, exp, seen);
            checks++;
            if (!seen || got !== exp) begin
                errors++;
                $display("FAIL pg_data%0d got=%h seen=%0d required=%h", i, got, seen, exp);
            end
`ifdef OLED_RX_ADDR_TRACK_EN
            if (i == 127 || i == 128) begin
                checks++;
                if (got.pg !== 2'd3 || got.col !== ((i == 127) ? 7'd127 : 7'd0)) begin
                    errors++;
                    $display("FAIL pg_wrap byte %0d got page=%0d col=%0d", i + 1, got.pg, got.col);
                end
            end
`endif
        end
    endtask

    task automatic test_frag();
        obs_t got, exp; bit seen;
        int f0;
        cs_low();
        f0 = frag_cnt;
        clock_bits(8'($urandom), 1'b1, 5, 1'b0);
        @(negedge CLK);
        CS = 1'b1;
        repeat (8) @(negedge CLK);
        checks++;
        if (frag_cnt - f0 !== 1 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL frag_pulse got pulses=%0d bytes=%0d required pulses=1 bytes=0",
                     frag_cnt - f0, obs_q.size());
        end
        obs_q.delete();
        cs_low();
        run_byte(8'h3C, 1'b1, 1'b0, got, exp, seen);
        checks++;
        if (!seen || got !== exp || got.d !== 8'h3C) begin
            errors++;
            $display("FAIL frag_recover got=%h seen=%0d required=%h", got, seen, exp);
        end
    endtask

    task automatic test_cs_same_edge();
        obs_t got, exp; bit seen;
        int f0;
        cs_low();
        f0 = frag_cnt;
        run_byte(8'($urandom), 1'($urandom), 1'b1, got, exp, seen);
        repeat (4) @(negedge CLK);
        checks++;
        if (!seen || got !== exp || frag_cnt != f0) begin
            errors++;
            $display("FAIL cs_same_edge got=%h seen=%0d frag=%0d required=%h frag=0",
                     got, seen, frag_cnt - f0, exp);
        end
    endtask

    task automatic test_reset_mid_byte();
        obs_t got, exp; bit seen;
        int f0;
        cs_low();
        clock_bits(8'($urandom), 1'b1, 4, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        f0 = frag_cnt;
        repeat (4) @(negedge CLK);
        CS = 1'b1;
        repeat (8) @(negedge CLK);
        checks++;
        if (frag_cnt != f0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_byte got pulses=%0d bytes=%0d required 0 0", frag_cnt - f0, obs_q.size());
        end
        obs_q.delete();
        cs_low();
        run_byte(8'h3C, 1'b1, 1'b0, got, exp, seen);
        checks++;
        if (!seen || got !== exp) begin
            errors++;
            $display("FAIL reset_mid_next got=%h seen=%0d required=%h", got, seen, exp);
        end
    endtask

    task automatic test_disp_cmd();
        obs_t got, exp; bit seen;
        logic [7:0] seq_b [4];
        bit         seq_dc [4];
        seq_b[0] = 8'hAF; seq_dc[0] = 1'b0;
        seq_b[1] = 8'h21; seq_dc[1] = 1'b0;
        seq_b[2] = 8'h55; seq_dc[2] = 1'b1;
        seq_b[3] = 8'hAE; seq_dc[3] = 1'b0;
        test_reset();
        cs_low();
        for (int i = 0; i < 4; i++) begin
            run_byte(seq_b[i], seq_dc[i], 1'b0, got, exp, seen);
            checks++;
            if (!seen || got !== exp || disp_on !== m_disp) begin
                errors++;
                $display("FAIL disp_seq%0d got=%h disp=%0d required=%h disp=%0d",
                         i, got, disp_on, exp, m_disp);
            end
        end
`ifdef OLED_RX_ADDR_TRACK_EN
        checks++;
        if (disp_on !== 1'b0) begin
            errors++;
            $display("FAIL disp_off got=%0d required=0", disp_on);
        end
`endif
    endtask

    task automatic test_random();
        obs_t got, exp; bit seen;
        logic [7:0] b;
        bit dc;
        int r;
        test_reset();
        cs_low();
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            dc = (r >= 5);
            case (r)
                0: b = 8'h21;
                1: b = 8'h22;
                2: b = 8'hAE;
                3: b = 8'hAF;
                default: b = 8'($urandom);
            endcase
            run_byte(b, dc, 1'b0, got, exp, seen);
            checks++;
            if (!seen || got !== exp || disp_on !== m_disp) begin
                errors++;
                $display("FAIL random%0d got=%h disp=%0d required=%h disp=%0d",
                         i, got, disp_on, exp, m_disp);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                CS = 1'b1;
                repeat (6) @(negedge CLK);
                cs_low();
            end
        end
    endtask

    task automatic test_strobes();
        repeat (8) @(negedge CLK);
        checks++;
        if (vld_long != 0 || frag_long != 0 || wr_bad != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL strobes got vld_long=%0d frag_long=%0d wr_stray=%0d extra=%0d required all 0",
                     vld_long, frag_long, wr_bad, obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_col_window();
        test_page_wrap();
        test_frag();
        test_cs_same_edge();
        test_reset_mid_byte();
        test_disp_cmd();
        test_random();
        test_strobes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
